// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte loader that deposits/examines RAM over a shared tri-state data bus
module mem_loader #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    input  logic [1:0]            cmd_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [7:0]            data_in,
    output logic                  rd_valid_out,
    output logic [7:0]            rd_data_out,
    output logic [ADDR_WIDTH-1:0] ptr_out,
    output logic                  write_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    inout  wire  [7:0]            bus_io
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CAPTURE,
        S_RESULT
    } state_t;

    localparam logic [1:0] CMD_SETADDR = 2'b00;
    localparam logic [1:0] CMD_DEPOSIT = 2'b01;
    localparam logic [1:0] CMD_EXAMINE = 2'b10;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [7:0]            wdata_q;
    logic [7:0]            rdata_q;
    logic                  write_q;
    logic                  ready_q;
    logic                  rd_valid_q;
    logic [ADDR_WIDTH-1:0] ptr_inc_d;

    assign ptr_inc_d = ptr_q + ADDR_WIDTH'(1);

    // Every output is a flop; ready/write/valid are set on the transition into the state that owns them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            write_q    <= 1'b0;
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_in && ready_q) begin
                        case (cmd_in)
                            CMD_SETADDR: ptr_q <= addr_in;
                            CMD_DEPOSIT: begin
                                wdata_q <= data_in;
                                write_q <= 1'b1;
                                ready_q <= 1'b0;
                                state_q <= S_WRITE;
                            end
                            CMD_EXAMINE: begin
                                ready_q <= 1'b0;
                                state_q <= S_READ;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WRITE: begin
                    write_q <= 1'b0;
                    ptr_q   <= ptr_inc_d;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_READ: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // RAM presents the byte registered at the end of READ during this cycle
                    rdata_q    <= bus_io;
                    ptr_q      <= ptr_inc_d;
                    rd_valid_q <= 1'b1;
                    state_q    <= S_RESULT;
                end
                S_RESULT: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    write_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_out = ready_q;
    assign rd_valid_out  = rd_valid_q;
    assign rd_data_out   = rdata_q;
    assign ptr_out       = ptr_q;
    assign write_out     = write_q;
    assign addr_out      = ptr_q;
    assign bus_io        = write_q ? wdata_q : 8'bz;

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, SHALL set the RAM address width (RAM depth 2^ADDR_WIDTH bytes).
REQ-002 clk_in  input  1  single clock, all state updates on rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid_in  input  1  command request.
REQ-005 cmd_ready_out  output  1  command accepted when cmd_valid_in && cmd_ready_out on a rising edge.
REQ-006 cmd_in  input  2  opcode: 00 SETADDR, 01 DEPOSIT, 10 EXAMINE, 11 NOP.
REQ-007 addr_in  input  ADDR_WIDTH  new pointer value for SETADDR.
REQ-008 data_in  input  8  byte to store for DEPOSIT.
REQ-009 rd_valid_out  output  1  one-cycle pulse, EXAMINE result present.
REQ-010 rd_data_out  output  8  last byte read, held until next EXAMINE result.
REQ-011 ptr_out  output  ADDR_WIDTH  current address pointer.
REQ-012 write_out  output  1  RAM write strobe (to RAM write_in).
REQ-013 addr_out  output  ADDR_WIDTH  RAM address (to RAM addr_in).
REQ-014 bus_io  inout  8  shared RAM data bus.

Function
REQ-015 FSM states SHALL be IDLE, WRITE, READ, CAPTURE, RESULT.
REQ-016 cmd_ready_out SHALL be 1 only in IDLE, registered, never combinationally dependent on cmd_valid_in.
REQ-017 IDLE + accepted SETADDR: ptr <= addr_in next edge, stay IDLE; no RAM access.
REQ-018 IDLE + accepted NOP: no state change; command consumed.
REQ-019 IDLE + accepted DEPOSIT: latch data_in, go WRITE.
REQ-020 WRITE: write_out=1, addr_out=ptr, bus_io driven with latched byte for exactly one cycle; at cycle end ptr <= ptr+1, go IDLE.
REQ-021 IDLE + accepted EXAMINE: go READ.
REQ-022 READ: write_out=0, addr_out=ptr, bus_io released; go CAPTURE (RAM registers data on this edge).
REQ-023 CAPTURE: addr_out=ptr held, bus_io sampled into rd_data_out at cycle end; ptr <= ptr+1; go RESULT.
REQ-024 RESULT: rd_valid_out=1 for this single cycle; go IDLE.
REQ-025 Command-to-ready latency: DEPOSIT 2 cycles, EXAMINE 4 cycles, SETADDR/NOP 1 cycle.
REQ-026 bus_io SHALL be driven only while write_out=1, high-Z otherwise, so RAM and loader never drive together.
REQ-027 write_out SHALL be 0 in every state except WRITE.
REQ-028 ptr increment SHALL wrap modulo 2^ADDR_WIDTH (max -> 0), no flag.
REQ-029 cmd_valid_in, cmd_in, addr_in, data_in SHALL be ignored outside IDLE; no queuing.
REQ-030 ptr_out SHALL equal ptr register; addr_out in IDLE SHALL equal ptr.

Reset
REQ-031 rst_in high at a rising edge SHALL force IDLE, ptr=0, rd_data_out=0x00, rd_valid_out=0, write_out=0, bus_io high-Z, cmd_ready_out=1 from next cycle, regardless of state.
REQ-032 Reset during WRITE SHALL abort before ptr increments; write_out low from the next cycle.
REQ-033 Reset during READ/CAPTURE/RESULT SHALL suppress any pending rd_valid_out pulse.

Verification
REQ-034 Reset, SETADDR 0x0100, DEPOSIT 0xA5, 0x5A -> RAM[0x0100]=0xA5, RAM[0x0101]=0x5A, ptr_out=0x0102, write_out high exactly 2 cycles total.
REQ-035 SETADDR 0x0100, EXAMINE x2 -> rd_valid_out pulses, rd_data_out 0xA5 then 0x5A, each 4 cycles after acceptance, ptr_out=0x0102.
REQ-036 SETADDR 0x3FFF, DEPOSIT 0x77, EXAMINE -> ptr wraps to 0x0000 after deposit; EXAMINE returns RAM[0x0000]; ptr_out=0x0001.
REQ-037 cmd_valid_in held high with changing cmd_in during WRITE/READ/CAPTURE/RESULT -> only the IDLE-cycle command executes; cmd_ready_out low in those states.
REQ-038 rst_in asserted in CAPTURE -> no rd_valid_out pulse, rd_data_out=0x00, ptr_out=0, write_out=0, bus_io high-Z next cycle.
REQ-039 Every cycle of all scenarios -> bus_io never driven by loader while write_out=0 (no X contention on bus).
